rc5_port_host: RTL and testbench

Host-side endpoint of the RC5 core's time-multiplexed W-bit serial port. It accepts one parallel request of four words (cipher plaintext A/B, decipher ciphertext A/B) and drives them onto `serial_port_in` in phase with the core's free-running 2-bit slot counter. It then pulses the start strobes and waits for both done flags. Finally it de-serializes `serial_port_out` back into four parallel result words and hands them out with a valid pulse.

---
 rtl/rc5_port_host.sv | 205 ++++++++++++++++++++
 tb/tb_rc5_port_host.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc5_port_host.sv
// rc5_port_host: host-side endpoint of the RC5 core's slot-multiplexed serial port.
// It takes four request words, presents them in slot order on serial_port_in,
// strobes both starts, waits for both done flags, collects four result words
// from serial_port_out and presents them with a one-cycle oValid pulse.
//
// Optional feature: define RC5_HOST_TIMEOUT_EN to bound WAIT to TIMEOUT cycles.
// On expiry, oError pulses for one cycle and the host returns to IDLE.
// Without the macro, oError is tied low and WAIT is unbounded.
//
// Handshake: a request transfers on a rising edge where iValid && oReady.
// oReady is high only in IDLE, and iValid is ignored elsewhere.
// oValid is a single-cycle pulse with no back-pressure.
// The result words hold their value until the next oValid.
//
// dbgState exposes the FSM state: 0 IDLE, 1 SEND, 2 START, 3 WAIT,
// 4 COLLECT, 5 DONE.
module rc5_port_host #(
   parameter int W       = 32,
   parameter int RX_LAT  = 1,
   parameter int TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         iValid,
   output logic         oReady,
   input  logic [W-1:0] iA,
   input  logic [W-1:0] iB,
   input  logic [W-1:0] iA_cipher,
   input  logic [W-1:0] iB_cipher,
   output logic [W-1:0] serial_port_in,
   input  logic [W-1:0] serial_port_out,
   output logic         oStartCipher,
   output logic         oStartDecipher,
   input  logic         iDoneCipher,
   input  logic         iDoneDecipher,
   output logic [W-1:0] oA_cipher,
   output logic [W-1:0] oB_cipher,
   output logic [W-1:0] oA_decipher,
   output logic [W-1:0] oB_decipher,
   output logic         oValid,
   output logic         oError,
   output logic [2:0]   dbgState
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SEND    = 3'd1,
      START   = 3'd2,
      WAIT    = 3'd3,
      COLLECT = 3'd4,
      DONE    = 3'd5
   } state_t;

   // Result latency expressed in the widths of the slot counter and phase counter.
   localparam logic [1:0] LAT2         = 2'(RX_LAT);
   localparam logic [2:0] LAT3         = 3'(RX_LAT);
   localparam logic [2:0] COLLECT_LAST = 3'(3 + RX_LAT);

   state_t         state;
   logic [1:0]     cnt;
   logic [2:0]     phase;
   logic           doneC;
   logic           doneD;
   logic [W-1:0]   tx [4];
   logic [W-1:0]   rx [4];
   logic [W-1:0]   rxNext [4];
   logic [1:0]     rxSlot;
   logic           doneCNext;
   logic           doneDNext;

`ifdef RC5_HOST_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] waitCnt;
`endif

   assign dbgState       = state;
   assign serial_port_in = tx[cnt];

   // The word on serial_port_out now belongs to the slot that was on the bus RX_LAT cycles ago.
   assign rxSlot    = cnt - LAT2;
   assign doneCNext = doneC | iDoneCipher;
   assign doneDNext = doneD | iDoneDecipher;

`ifndef RC5_HOST_TIMEOUT_EN
   assign oError = 1'b0;
`endif

   // Free-running slot counter that mirrors the core's counter; both share rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= 2'd0;
      else     cnt <= cnt + 2'd1;
   end

   // Receive buffer with the current cycle's capture merged in, so DONE sees the last word.
   always_comb begin
      rxNext = rx;
      if (state == COLLECT && phase >= LAT3)
         rxNext[rxSlot] = serial_port_out;
   end

   // Control FSM: request latch, slot send, start strobe, done wait, collect, publish.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         phase          <= 3'd0;
         doneC          <= 1'b0;
         doneD          <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            tx[i] <= '0;
            rx[i] <= '0;
         end
         oA_cipher      <= '0;
         oB_cipher      <= '0;
         oA_decipher    <= '0;
         oB_decipher    <= '0;
         oReady         <= 1'b1;
         oValid         <= 1'b0;
         oStartCipher   <= 1'b0;
         oStartDecipher <= 1'b0;
`ifdef RC5_HOST_TIMEOUT_EN
         waitCnt        <= '0;
         oError         <= 1'b0;
`endif
      end else begin
         oValid         <= 1'b0;
         oStartCipher   <= 1'b0;
         oStartDecipher <= 1'b0;
`ifdef RC5_HOST_TIMEOUT_EN
         oError         <= 1'b0;
`endif
         rx <= rxNext;
         case (state)
            IDLE: begin
               if (iValid) begin
                  tx[0]  <= iA;
                  tx[1]  <= iB;
                  tx[2]  <= iA_cipher;
                  tx[3]  <= iB_cipher;
                  phase  <= 3'd0;
                  oReady <= 1'b0;
                  state  <= SEND;
               end
            end
            SEND: begin
               // Four cycles cover all four slot phases, whatever phase the accept landed on.
               if (phase == 3'd3) begin
                  phase          <= 3'd0;
                  oStartCipher   <= 1'b1;
                  oStartDecipher <= 1'b1;
                  state          <= START;
               end else begin
                  phase <= phase + 3'd1;
               end
            end
            START: begin
               // Done flags raised before the start strobe are stale and are discarded.
               doneC <= 1'b0;
               doneD <= 1'b0;
`ifdef RC5_HOST_TIMEOUT_EN
               waitCnt <= '0;
`endif
               state <= WAIT;
            end
            WAIT: begin
               doneC <= doneCNext;
               doneD <= doneDNext;
               if (doneCNext && doneDNext) begin
                  phase <= 3'd0;
                  state <= COLLECT;
               end
`ifdef RC5_HOST_TIMEOUT_EN
               else if (waitCnt == TW'(TIMEOUT - 1)) begin
                  oError <= 1'b1;
                  oReady <= 1'b1;
                  state  <= IDLE;
               end else begin
                  waitCnt <= waitCnt + 1'b1;
               end
`endif
            end
            COLLECT: begin
               if (phase == COLLECT_LAST) begin
                  oA_cipher   <= rxNext[0];
                  oB_cipher   <= rxNext[1];
                  oA_decipher <= rxNext[2];
                  oB_decipher <= rxNext[3];
                  oValid      <= 1'b1;
                  state       <= DONE;
               end else begin
                  phase <= phase + 3'd1;
               end
            end
            DONE: begin
               oReady <= 1'b1;
               state  <= IDLE;
            end
            default: begin
               oReady <= 1'b1;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rc5_port_host.sv
// tb_rc5_port_host: self-checking bench for rc5_port_host.
// The core model echoes each slot word back after RX_LAT cycles.
// It raises each done flag a programmable number of cycles after the start strobe.
// Expected results are the accepted request words.
// Expected timing follows from the slot and latency rules.
module tb_rc5_port_host;

   localparam int W        = 32;
   localparam int RX_LAT   = 1;
   localparam int PIPE_IDX = (RX_LAT == 0) ? 0 : RX_LAT - 1;

   logic         clk;
   logic         rst;
   logic         iValid;
   logic         oReady;
   logic [W-1:0] iA, iB, iA_cipher, iB_cipher;
   logic [W-1:0] serial_port_in;
   logic [W-1:0] serial_port_out;
   logic         oStartCipher, oStartDecipher;
   logic         iDoneCipher, iDoneDecipher;
   logic [W-1:0] oA_cipher, oB_cipher, oA_decipher, oB_decipher;
   logic         oValid;
   logic         oError;
   logic [2:0]   dbgState;

   int checks   = 0;
   int failures = 0;

   rc5_port_host #(.W(W), .RX_LAT(RX_LAT), .TIMEOUT(1024)) dut (
      .clk            (clk),
      .rst            (rst),
      .iValid         (iValid),
      .oReady         (oReady),
      .iA             (iA),
      .iB             (iB),
      .iA_cipher      (iA_cipher),
      .iB_cipher      (iB_cipher),
      .serial_port_in (serial_port_in),
      .serial_port_out(serial_port_out),
      .oStartCipher   (oStartCipher),
      .oStartDecipher (oStartDecipher),
      .iDoneCipher    (iDoneCipher),
      .iDoneDecipher  (iDoneDecipher),
      .oA_cipher      (oA_cipher),
      .oB_cipher      (oB_cipher),
      .oA_decipher    (oA_decipher),
      .oB_decipher    (oB_decipher),
      .oValid         (oValid),
      .oError         (oError),
      .dbgState       (dbgState)
   );

   // ---- clock / reset ----
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---- reference slot counter: reset by rst, counts every rising edge ----
   logic [1:0] tbCnt;
   always @(posedge clk or posedge rst) begin
      if (rst) tbCnt <= 2'd0;
      else     tbCnt <= tbCnt + 2'd1;
   end

   // ---- core model: echo of serial_port_in delayed by RX_LAT cycles ----
   logic [W-1:0] pipe [4];
   always @(posedge clk) begin
      pipe[0] <= serial_port_in;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
   end
   assign serial_port_out = (RX_LAT == 0) ? serial_port_in : pipe[PIPE_IDX];

   // ---- core model: each done goes high delay cycles after the start strobe ----
   int delayC = 0;
   int delayD = 0;
   int cntC, cntD;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         iDoneCipher   <= 1'b0;
         iDoneDecipher <= 1'b0;
         cntC          <= 0;
         cntD          <= 0;
      end else begin
         if (oStartCipher) begin
            iDoneCipher <= (delayC == 0);
            cntC        <= delayC;
         end else if (cntC > 0) begin
            cntC <= cntC - 1;
            if (cntC == 1) iDoneCipher <= 1'b1;
         end
         if (oStartDecipher) begin
            iDoneDecipher <= (delayD == 0);
            cntD          <= delayD;
         end else if (cntD > 0) begin
            cntD <= cntD - 1;
            if (cntD == 1) iDoneDecipher <= 1'b1;
         end
      end
   end

   // ---- scoreboard ----
   logic [W-1:0] exp_q [$];
   logic [W-1:0] prevRes [4];

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---- driver: one full transaction, checked cycle by cycle ----
   // Cycle k is the clock period ending at rising edge E0+k.
   // Outputs are sampled on the falling edge inside that period.
   task automatic runTxn(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ac, input logic [W-1:0] bc,
                         input int dC, input int dD, input int acceptPhase, input bit hold);
      logic [W-1:0] req [4];
      logic [W-1:0] got [4];
      int validAt;
      int readyHigh;
      int extraStart;
      int maxD;
      req[0] = a; req[1] = b; req[2] = ac; req[3] = bc;
      maxD = (dC > dD) ? dC : dD;
      if (acceptPhase >= 0) begin
         for (int g = 0; g < 8 && int'(tbCnt) != acceptPhase; g++) @(negedge clk);
      end
      check("ready_before_accept", W'(oReady), W'(1));
      delayC    = dC;
      delayD    = dD;
      iA        = a;
      iB        = b;
      iA_cipher = ac;
      iB_cipher = bc;
      iValid    = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back(req[i]);
      @(posedge clk);
      validAt    = 0;
      readyHigh  = 0;
      extraStart = 0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (!hold) iValid = 1'b0;
            check("hold_oA_cipher", oA_cipher, prevRes[0]);
            check("hold_oB_decipher", oB_decipher, prevRes[3]);
         end
         if (hold) begin
            iA        = $urandom;
            iB        = $urandom;
            iA_cipher = $urandom;
            iB_cipher = $urandom;
         end
         if (k <= 4) check("send_slot_word", serial_port_in, req[tbCnt]);
         if (k == 5) begin
            check("start_cipher", W'(oStartCipher), W'(1));
            check("start_decipher", W'(oStartDecipher), W'(1));
         end else if (oStartCipher || oStartDecipher) begin
            extraStart++;
         end
         if (oReady) readyHigh++;
         if (oValid) begin
            validAt = k;
            break;
         end
      end
      check("valid_latency", W'(validAt), W'(11 + RX_LAT + maxD));
      check("ready_low_while_busy", W'(readyHigh), W'(0));
      check("extra_start_strobes", W'(extraStart), W'(0));
      got[0] = oA_cipher; got[1] = oB_cipher; got[2] = oA_decipher; got[3] = oB_decipher;
      for (int i = 0; i < 4; i++) begin
         logic [W-1:0] e;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         check("result_word", got[i], e);
         prevRes[i] = e;
      end
      @(negedge clk);
      check("valid_single_pulse", W'(oValid), W'(0));
      check("ready_after_done", W'(oReady), W'(1));
      check("result_held", oA_cipher, prevRes[0]);
   endtask

   // ---- directed sequence ----
   initial begin
      int validDuring;
      rst       = 1'b1;
      iValid    = 1'b0;
      iA        = '0;
      iB        = '0;
      iA_cipher = '0;
      iB_cipher = '0;
      for (int i = 0; i < 4; i++) prevRes[i] = '0;
      repeat (3) @(negedge clk);

      // Reset state.
      check("rst_ready", W'(oReady), W'(1));
      check("rst_valid", W'(oValid), W'(0));
      check("rst_error", W'(oError), W'(0));
      check("rst_start", W'({oStartCipher, oStartDecipher}), W'(0));
      check("rst_state_idle", W'(dbgState), W'(0));
      check("rst_serial_in", serial_port_in, '0);
      check("rst_oA_cipher", oA_cipher, '0);
      check("rst_oB_decipher", oB_decipher, '0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic request: done flags seen in the first WAIT cycle.
      runTxn(32'h0000_0000, 32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 0, 0, -1, 1'b0);

      // Accept while the slot counter is at 2.
      runTxn($urandom, $urandom, $urandom, $urandom, 0, 0, 2, 1'b0);

      // Decipher done five cycles before cipher done.
      runTxn($urandom, $urandom, $urandom, $urandom, 6, 1, -1, 1'b0);

      // iValid held high throughout: one accept per transaction, back to back.
      runTxn($urandom, $urandom, $urandom, $urandom, 0, 2, -1, 1'b1);
      runTxn($urandom, $urandom, $urandom, $urandom, 3, 0, -1, 1'b1);
      runTxn($urandom, $urandom, $urandom, $urandom, 1, 1, -1, 1'b0);

      // Randomized requests, done delays and accept phases.
      for (int t = 0; t < 6; t++) begin
         runTxn($urandom, $urandom, $urandom, $urandom,
                $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 3), 1'b0);
      end

      // Reset in the middle of WAIT.
      delayC    = 30;
      delayD    = 30;
      iA        = $urandom;
      iB        = $urandom;
      iA_cipher = $urandom;
      iB_cipher = $urandom;
      iValid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iValid = 1'b0;
      repeat (7) @(negedge clk);
      check("wait_state_before_rst", W'(dbgState), W'(3));
      rst = 1'b1;
      #1;
      check("midrst_state_idle", W'(dbgState), W'(0));
      check("midrst_ready", W'(oReady), W'(1));
      check("midrst_valid", W'(oValid), W'(0));
      check("midrst_oA_cipher", oA_cipher, '0);
      check("midrst_oB_cipher", oB_cipher, '0);
      check("midrst_oA_decipher", oA_decipher, '0);
      check("midrst_oB_decipher", oB_decipher, '0);
      check("midrst_serial_in", serial_port_in, '0);
      for (int i = 0; i < 4; i++) prevRes[i] = '0;
      validDuring = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 3) rst = 1'b0;
         if (oValid) validDuring++;
      end
      check("no_valid_after_abort", W'(validDuring), W'(0));

      // Recovery after the aborted transaction.
      runTxn($urandom, $urandom, $urandom, $urandom, 2, 4, -1, 1'b0);
      check("error_tied_low", W'(oError), W'(0));
      check("scoreboard_drained", W'(exp_q.size()), W'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
